// File: rtl/seq_scan_sched.sv
// Round-robin front end that shares one external serial sequence detector among N_REQ requesters.
// Each granted word is shifted in MSB first and the detector hits in its window are returned as a count.
module seq_scan_sched #(
  parameter int N_REQ   = 4,
  parameter int WORD_W  = 16,
  parameter int CNT_W   = $clog2(WORD_W + 1),
  parameter int DET_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WORD_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       det_clr,
  output logic                       det_din,
  input  logic                       det_dout,
  output logic                       res_valid,
  output logic [$clog2(N_REQ)-1:0]   res_id,
  output logic [CNT_W-1:0]           res_count,
  input  logic                       res_ready,
  output logic                       busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CYC_W = $clog2(WORD_W + DET_LAT + 1);
  localparam logic [CYC_W-1:0] LAST_SHIFT = CYC_W'(WORD_W - 1);
  localparam logic [CYC_W-1:0] LAST_DRAIN = CYC_W'(WORD_W + DET_LAT - 1);
  localparam logic [CYC_W-1:0] WIN_START  = CYC_W'(DET_LAT);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN, S_RESULT} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_q, last_d;

  logic [WORD_W-1:0] req_word [N_REQ];
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic              hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*WORD_W +: WORD_W];
    end
  endgenerate

  // Search starts one past the last grant, so the last winner has lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!gnt_found && req_valid[(int'(last_q) + k) % N_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'((int'(last_q) + k) % N_REQ);
      end
    end
  end

  // cyc_q counts SHIFT and DRAIN cycles; the first DET_LAT samples still belong to stale detector state.
  assign hit = det_dout && (cyc_q >= WIN_START);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cyc_d     = cyc_q;
    count_d   = count_q;
    id_d      = id_q;
    last_d    = last_q;
    req_ready = '0;
    det_clr   = 1'b0;
    det_din   = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found && reset) begin
          req_ready[gnt_idx] = 1'b1;
          shreg_d = req_word[gnt_idx];
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        det_clr = 1'b1;
        count_d = '0;
        cyc_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        det_din = shreg_q[WORD_W-1];
        shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
        cyc_d   = cyc_q + CYC_W'(1);
        if (hit) count_d = count_q + CNT_W'(1);
        if (cyc_q == LAST_SHIFT) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (hit) count_d = count_q + CNT_W'(1);
        if (cyc_q == LAST_DRAIN) state_d = S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cyc_q   <= '0;
      count_q <= '0;
      id_q    <= '0;
      last_q  <= ID_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cyc_q   <= cyc_d;
      count_q <= count_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign res_id    = id_q;
  assign res_count = count_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/seq_scan_sched.md
Name: seq_scan_sched

Overview:
- Sequencer that shares one serial sequence detector (1-bit din/dout, synchronous active-high reset) among N_REQ requesters.
- Each requester submits a WORD_W-bit word. The block arbitrates round-robin, clears the detector, shifts the word into it MSB first, and counts detector hits inside the word's window.
- Returns {requester id, hit count} on a valid/ready result port.
- Sits between the requesters and the detector instance; the detector itself is external.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- WORD_W, 16, bits per submitted word (>=2).
- CNT_W, $clog2(WORD_W+1), width of the hit count.
- DET_LAT, 1, cycles from det_din presented to the corresponding det_dout (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  request i holds a word.
- req_data  in  N_REQ*WORD_W  word i at bits [i*WORD_W +: WORD_W].
- req_ready  out  N_REQ  one-hot grant pulse; the word is accepted this cycle.
- det_clr  out  1  synchronous clear to the detector's reset input.
- det_din  out  1  serial bit to the detector.
- det_dout  in  1  detector match output.
- res_valid  out  1  result available.
- res_id  out  $clog2(N_REQ)  requester the result belongs to.
- res_count  out  CNT_W  number of det_dout highs in the word window.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - All outputs 0: req_ready, det_clr, det_din, res_valid, res_id, res_count, busy.
  - Shift register, counters and hit count = 0.
  - Round-robin pointer = N_REQ-1, so requester 0 has highest priority after reset.
- FSM: IDLE -> CLEAR -> SHIFT -> DRAIN -> RESULT -> IDLE.
- IDLE:
  - If any req_valid, grant the first valid requester searching from (last_grant+1) mod N_REQ upward, wrapping.
  - req_ready[g]=1 for exactly that cycle (combinational from state and req_valid). The word is latched into the shift register, g is latched as res_id, last_grant=g, and the FSM goes to CLEAR.
  - No valid request: stay in IDLE, req_ready=0.
- CLEAR: 1 cycle; det_clr=1, det_din=0, hit count zeroed.
- SHIFT:
  - WORD_W cycles; det_din = shift register MSB, shift left by 1 each cycle.
  - Bit k (k=0 is the MSB) is driven in SHIFT cycle k.
- DRAIN: DET_LAT cycles; det_din=0.
- Counting window: det_dout is sampled each cycle from SHIFT cycle DET_LAT through the last DRAIN cycle, exactly WORD_W samples. Each high sample increments the hit count.
- Hit count range: max count = WORD_W, which fits in CNT_W; no saturation logic is needed.
- RESULT:
  - res_valid=1; res_id and res_count are held stable until res_valid && res_ready.
  - On the handshake, go to IDLE next cycle and deassert res_valid.
  - No arbitration occurs in RESULT; a new grant is possible from the cycle after the handshake.
- det_clr and det_din are 0 in every state other than those stated above.
- Throughput: with res_ready tied high, each word occupies 1 (grant) + 1 + WORD_W + DET_LAT + 1 cycles.
- Boundary conditions:
  - req_valid dropping in IDLE before a grant is legal; nothing is latched.
  - req_valid changes during a busy period are ignored until IDLE.
  - A single persistent requester is granted back-to-back; the pointer wraps past itself to it.
  - Reset mid-operation aborts the word with no result, and the next grant starts from requester 0. The detector is cleared by the next CLEAR.
  - det_dout highs outside the counting window are ignored.

Test Plan:
Bench drives det_dout from a behavioural detector: pattern 1011, overlapping matches allowed, synchronous clear, DET_LAT=1.
1. Single word: req0 with 16'hB000 -> one req_ready[0] pulse, det_din serial 1011 then 0s, res_valid with res_id=0, res_count=1, busy high for 19 cycles (CLEAR, 16 SHIFT, DRAIN, RESULT).
2. Overlap and extremes: words 16'hBBBB, 16'h0000, 16'hFFFF on req1 -> res_count 4, 0, 0 in order, each with res_id=1.
3. Round-robin: all four req_valid held high with distinct words -> grant order 0,1,2,3,0. Each res_id matches its grant, and there is exactly one req_ready pulse per grant.
4. Backpressure: hold res_ready low for 5 cycles in RESULT -> res_valid, res_id, res_count stable; no req_ready pulses. Handshake on cycle 6, next grant the cycle after.
5. Reset mid-shift: assert reset at SHIFT bit 7 -> all outputs 0 immediately, no result emitted. After release, with req0 and req2 valid, req0 is granted first.
6. Window edge: force det_dout high during CLEAR and during SHIFT cycle 0 only -> res_count=0.
